// File: rtl/i2s_adc_rx_pkg.sv
// rtl/i2s_adc_rx_pkg.sv - shared encodings for the I2S ADC receiver
package i2s_adc_rx_pkg;

  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/i2s_in_sync.sv
// rtl/i2s_in_sync.sv - two-flop synchroniser for asynchronous I2S pins
module i2s_in_sync #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/i2s_adc_rx.sv
// rtl/i2s_adc_rx.sv - I2S slave receiver: deserialises stereo ADC frames, tracks lock and format errors
module i2s_adc_rx
  import i2s_adc_rx_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int TIMEOUT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i2s_bck,
  input  logic              i2s_lrck,
  input  logic              i2s_din,
  output logic [DATA_W-1:0] left,
  output logic [DATA_W-1:0] right,
  output logic              valid,
  output logic              locked,
  output logic              fmt_err
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0]     MSB_POS  = CNT_W'(DATA_W - 1);
  localparam logic [TIMEOUT_W-1:0] TMO_MAX  = '1;

  logic [2:0] pins_s;
  logic       bck_s2, lrck_s2, din_s2, bck_s3, rise;

  i2s_in_sync #(.WIDTH(3)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     ({i2s_bck, i2s_lrck, i2s_din}),
    .q     (pins_s)
  );

  assign {bck_s2, lrck_s2, din_s2} = pins_s;

  always_ff @(posedge clk) begin
    if (reset) bck_s3 <= 1'b0;
    else       bck_s3 <= bck_s2;
  end

  // DIN/LRCK share the BCK sync delay, so they are sampled in the rise-detect cycle
  assign rise = bck_s2 & ~bck_s3;

  state_t                state, state_nx;
  logic [DATA_W-1:0]     shreg, word, left_hold;
  logic [CNT_W-1:0]      bit_cnt, cnt_nx;
  logic [TIMEOUT_W-1:0]  tmo;
  logic                  primed, lrck_prev;
  logic                  boundary, timeout, commit_l, commit_r, short_word;

  always_comb begin
    word   = shreg;
    cnt_nx = bit_cnt;
    if (bit_cnt < CNT_FULL) begin
      word   = shreg | (DATA_W'(din_s2) << (MSB_POS - bit_cnt));
      cnt_nx = bit_cnt + CNT_W'(1);
    end
  end

  assign boundary = rise & primed & (lrck_s2 != lrck_prev);
  // timeout fires on the edge where tmo reaches its saturation value; a rise always wins
  assign timeout  = ~rise & (tmo >= TMO_MAX - TIMEOUT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) state <= ST_HUNT;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (timeout) begin
      state_nx = ST_HUNT;
    end else if (boundary) begin
      case (state)
        ST_HUNT: if (lrck_prev) state_nx = ST_FILL;
        ST_FILL: if (lrck_prev) state_nx = ST_RUN;
        default: state_nx = state;
      endcase
    end
  end

  always_comb begin
    commit_l   = boundary & ~lrck_prev & (state != ST_HUNT);
    commit_r   = boundary &  lrck_prev & (state != ST_HUNT);
    short_word = (commit_l | commit_r) & (cnt_nx < CNT_FULL);
    locked     = (state == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      left      <= '0;
      right     <= '0;
      left_hold <= '0;
      valid     <= 1'b0;
      fmt_err   <= 1'b0;
      shreg     <= '0;
      bit_cnt   <= '0;
      tmo       <= '0;
      primed    <= 1'b0;
      lrck_prev <= 1'b0;
    end else begin
      valid   <= commit_r;
      fmt_err <= short_word;
      if (commit_l) left_hold <= word;
      if (commit_r) begin
        left  <= left_hold;
        right <= word;
      end
      if (rise) begin
        tmo       <= '0;
        primed    <= 1'b1;
        lrck_prev <= lrck_s2;
        if (boundary) begin
          shreg   <= '0;
          bit_cnt <= '0;
        end else begin
          shreg   <= word;
          bit_cnt <= cnt_nx;
        end
      end else begin
        if (tmo != TMO_MAX) tmo <= tmo + TIMEOUT_W'(1);
        if (timeout) primed <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_adc_rx.sv
// tb/tb_i2s_adc_rx.sv - directed scoreboard bench for the I2S ADC receiver
module tb_i2s_adc_rx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bck = 1'b0, lrck = 1'b1, din = 1'b0;
  logic [15:0] left, right;
  logic        valid, locked, fmt_err;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_rise = 0;
  int          half = 4;
  int          fmt_cnt = 0;
  logic        carry = 1'b0;
  logic        rst_q = 1'b1;
  logic [15:0] prev_left = '0, prev_right = '0;
  logic [31:0] exp_q[$];

  i2s_adc_rx #(.DATA_W(16), .TIMEOUT_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .i2s_bck  (bck),
    .i2s_lrck (lrck),
    .i2s_din  (din),
    .left     (left),
    .right    (right),
    .valid    (valid),
    .locked   (locked),
    .fmt_err  (fmt_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  // scoreboard side: every valid must match the oldest pushed frame
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst_q && !valid) begin
      checks++;
      assert (left === prev_left && right === prev_right) else begin
        errors++;
        $error("FAIL hold: left/right %h/%h changed without valid, was %h/%h", left, right, prev_left, prev_right);
      end
    end
    if (valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_valid: got %h/%h, no frame expected", left, right);
      end else begin
        e = exp_q.pop_front();
        checks++;
        assert (left === e[31:16] && right === e[15:0]) else begin
          errors++;
          $error("FAIL frame: got %h/%h want %h/%h", left, right, e[31:16], e[15:0]);
        end
        checks++;
        assert (locked === 1'b1) else begin
          errors++;
          $error("FAIL locked_at_valid: got %b want 1", locked);
        end
      end
    end
    if (fmt_err) fmt_cnt++;
    prev_left  = left;
    prev_right = right;
  end

  function automatic logic [15:0] expw(input logic [31:0] w, input int n);
    if (n >= 16) return 16'(w >> (n - 16));
    return 16'(w << (16 - n));
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic bck_cycle(input logic lr, input logic d);
    bck = 1'b0; lrck = lr; din = d;
    repeat (half) @(negedge clk);
    bck = 1'b1; last_rise = cyc;
    repeat (half) @(negedge clk);
  endtask

  // bit k=0 of a slot carries the previous word's LSB, MSB follows one BCK after the LRCK edge
  task automatic slot_bits(input logic lr, input logic [31:0] w, input int n, input int k0, input int k1);
    for (int k = k0; k < k1; k++) bck_cycle(lr, (k == 0) ? carry : w[n-k]);
    if (k1 == n) carry = w[0];
  endtask

  task automatic slot(input logic lr, input logic [31:0] w, input int n);
    slot_bits(lr, w, n, 0, n);
  endtask

  task automatic frame(input logic [31:0] l, input logic [31:0] r, input int n, input bit expect_valid);
    slot(1'b0, l, n);
    slot(1'b1, r, n);
    if (expect_valid) exp_q.push_back({expw(l, n), expw(r, n)});
  endtask

  task automatic tail_and_settle();
    bck_cycle(1'b0, carry);
    repeat (6) @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int f0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_left", left, 0);
    chk("rst_right", right, 0);
    chk("rst_valid", valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_fmt_err", fmt_err, 0);

    // 16-bit slots, three frames
    f0 = fmt_cnt;
    slot(1'b1, 32'h0, 16);
    for (int i = 0; i < 3; i++) frame(32'hA55A, 32'h1234, 16, 1'b1);
    tail_and_settle();
    chk("t1_left", left, 16'hA55A);
    chk("t1_right", right, 16'h1234);
    chk("t1_locked", locked, 1);
    chk("t1_fmt", fmt_cnt - f0, 0);
    chk("t1_drain", exp_q.size(), 0);

    // reset released during a right word: only full pairs afterwards produce frames
    reset = 1'b1;
    slot(1'b0, 32'h1111, 16);
    slot_bits(1'b1, 32'h2222, 16, 0, 8);
    reset = 1'b0;
    slot_bits(1'b1, 32'h2222, 16, 8, 16);
    frame(32'h3333, 32'h4444, 16, 1'b1);
    frame(32'h5555, 32'h6666, 16, 1'b1);
    tail_and_settle();
    chk("t2_left", left, 16'h5555);
    chk("t2_right", right, 16'h6666);
    chk("t2_drain", exp_q.size(), 0);

    // 24-bit slots are truncated
    pulse_reset();
    f0 = fmt_cnt;
    slot(1'b1, 32'h0, 24);
    frame(32'hABCDEF, 32'h123456, 24, 1'b1);
    frame(32'hABCDEF, 32'h123456, 24, 1'b1);
    tail_and_settle();
    chk("t3_left", left, 16'hABCD);
    chk("t3_right", right, 16'h1234);
    chk("t3_fmt", fmt_cnt - f0, 0);
    chk("t3_drain", exp_q.size(), 0);

    // 12-bit slots are zero-padded and flagged at every committed word
    pulse_reset();
    f0 = fmt_cnt;
    slot(1'b1, 32'h0, 12);
    frame(32'hFFF, 32'h801, 12, 1'b1);
    frame(32'hFFF, 32'h801, 12, 1'b1);
    tail_and_settle();
    chk("t4_left", left, 16'hFFF0);
    chk("t4_right", right, 16'h8010);
    chk("t4_fmt", fmt_cnt - f0, 4);
    chk("t4_drain", exp_q.size(), 0);

    // BCK loss at 32-bit slots
    pulse_reset();
    slot(1'b1, 32'h0, 32);
    frame(32'hDEADBEEF, 32'hCAFEF00D, 32, 1'b1);
    frame(32'h89ABCDEF, 32'h01234567, 32, 1'b1);
    tail_and_settle();
    chk("t5_locked_before", locked, 1);
    begin
      int n = 0;
      while (locked === 1'b1 && n < 400) begin
        @(negedge clk);
        n++;
      end
    end
    chk("t5_unlocked", locked, 0);
    checks++;
    assert (cyc - last_rise >= 255 && cyc - last_rise <= 260) else begin
      errors++;
      $error("FAIL t5_timeout_delay: got %0d clk want 255..260", cyc - last_rise);
    end
    repeat (50) @(negedge clk);
    chk("t5_hold_left", left, 16'h89AB);
    chk("t5_hold_right", right, 16'h0123);
    slot(1'b1, 32'h0, 32);
    slot(1'b0, 32'h76543210, 32);
    chk("t5_not_yet_locked", locked, 0);
    slot(1'b1, 32'hFEDCBA98, 32);
    exp_q.push_back({16'h7654, 16'hFEDC});
    tail_and_settle();
    chk("t5_relocked", locked, 1);
    chk("t5_drain", exp_q.size(), 0);

    // one-clock reset mid left word at BCK = clk/4
    half = 2;
    pulse_reset();
    slot(1'b1, 32'h0, 16);
    frame(32'h0F0F, 32'hF0F0, 16, 1'b1);
    slot_bits(1'b0, 32'h1357, 16, 0, 10);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_rst_left", left, 0);
    chk("t6_rst_right", right, 0);
    chk("t6_rst_locked", locked, 0);
    slot_bits(1'b0, 32'h1357, 16, 10, 16);
    slot(1'b1, 32'h2468, 16);
    frame(32'h9ABC, 32'hDEF0, 16, 1'b1);
    tail_and_settle();
    chk("t6_left", left, 16'h9ABC);
    chk("t6_right", right, 16'hDEF0);
    chk("t6_locked", locked, 1);
    chk("t6_drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
